// File: rtl/alu_pkg.sv
// Shared ALU datapath constants used by the result selector/distributor blocks.
package alu_pkg;

  localparam int unsigned ALU_WIDTH    = 16;
  localparam int unsigned ALU_SEL_W    = 4;
  localparam int unsigned ALU_CHANNELS = 2 ** ALU_SEL_W;

endpackage

// File: rtl/demux_channel.sv
// One holding channel of the result distributor: a data register plus its full flag.
module demux_channel #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             ack_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             full_d_o
);

  logic [Width-1:0] data_q, data_d;
  logic             full_q, full_d;

  // A load wins over an ack, so write+ack on the same channel keeps it full.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clr_i) begin
      data_d = '0;
      full_d = 1'b0;
    end else if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (ack_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o   = data_q;
  assign full_o   = full_q;
  assign full_d_o = full_d;

endmodule

// File: rtl/demux_1x16.sv
// Registered 1-to-16 result distributor with per-channel full flags and acknowledge.
module demux_1x16
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SEL_W = ALU_SEL_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  output logic [(2**SEL_W)*WIDTH-1:0] y_out,
  output logic [(2**SEL_W)-1:0]       y_valid,
  input  logic [(2**SEL_W)-1:0]       y_ack,
  output logic [SEL_W:0]              occupancy
);

  localparam int unsigned NumCh = 2 ** SEL_W;

  logic             fire;
  logic [NumCh-1:0] load;
  logic [NumCh-1:0] full_d;
  logic [SEL_W:0]   occ_q, occ_d;

  assign in_ready = !clr && (!y_valid[in_sel] || y_ack[in_sel]);
  assign fire     = in_valid && in_ready;

  // Gating by fire keeps a don't-care select from disturbing any channel.
  always_comb begin
    load = '0;
    for (int k = 0; k < NumCh; k++) begin
      load[k] = fire && (in_sel == SEL_W'(k));
    end
  end

  for (genvar k = 0; k < NumCh; k++) begin : g_ch
    demux_channel #(
      .Width(WIDTH)
    ) u_ch (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clr_i   (clr),
      .load_i  (load[k]),
      .ack_i   (y_ack[k]),
      .data_i  (in_data),
      .data_o  (y_out[k*WIDTH +: WIDTH]),
      .full_o  (y_valid[k]),
      .full_d_o(full_d[k])
    );
  end

  // Counting next-state flags keeps occupancy in step with y_valid.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < NumCh; k++) begin
      occ_d = occ_d + (SEL_W + 1)'(full_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_demux_1x16.sv
// Directed self-checking bench for demux_1x16.
module tb_demux_1x16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic [3:0]   in_sel;
  logic [255:0] y_out;
  logic [15:0]  y_valid;
  logic [15:0]  y_ack;
  logic [4:0]   occupancy;

  int n_vec = 0;
  int n_bad = 0;
  logic [255:0] exp_out;

  demux_1x16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .y_ack    (y_ack),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] sel, input logic [15:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; y_ack = '0;
    #12;
    check("rst_valid", 256'(y_valid), 256'h0);
    check("rst_occ", 256'(occupancy), 256'd0);
    check("rst_out", y_out, 256'h0);
    rst_n = 1'b1;
    step();

    // Mid-operation asynchronous reset with channels 2 and 9 full
    write(4'd2, 16'h2222);
    write(4'd9, 16'h9999);
    check("pre_rst_occ", 256'(occupancy), 256'd2);
    check("pre_rst_valid", 256'(y_valid), 256'h0204);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 256'(y_valid), 256'h0);
    check("arst_out", y_out, 256'h0);
    check("arst_occ", 256'(occupancy), 256'd0);
    #1 rst_n = 1'b1;
    #1;
    check("arst_ready", 256'(in_ready), 256'd1);
    step();

    // Single write
    in_valid = 1'b1; in_sel = 4'd3; in_data = 16'hA5A5;
    #1;
    check("w3_ready", 256'(in_ready), 256'd1);
    step();
    in_valid = 1'b0;
    check("w3_slice", 256'(y_out[63:48]), 256'hA5A5);
    check("w3_others", y_out & ~(256'hFFFF << 48), 256'h0);
    check("w3_valid", 256'(y_valid), 256'h0008);
    check("w3_occ", 256'(occupancy), 256'd1);

    // Back-pressure on full channel, then write+ack same channel
    in_valid = 1'b1; in_sel = 4'd3; in_data = 16'h1234;
    #1;
    check("bp_ready", 256'(in_ready), 256'd0);
    step();
    check("bp_hold", 256'(y_out[63:48]), 256'hA5A5);
    y_ack = 16'h0008;
    #1;
    check("wa_ready", 256'(in_ready), 256'd1);
    step();
    in_valid = 1'b0; y_ack = '0;
    check("wa_slice", 256'(y_out[63:48]), 256'h1234);
    check("wa_valid", 256'(y_valid), 256'h0008);
    check("wa_occ", 256'(occupancy), 256'd1);

    // Ack channel 3 together with a write to channel 4
    in_valid = 1'b1; in_sel = 4'd4; in_data = 16'h4444; y_ack = 16'h0008;
    step();
    in_valid = 1'b0; y_ack = '0;
    check("xj_valid", 256'(y_valid), 256'h0010);
    check("xj_occ", 256'(occupancy), 256'd1);
    y_ack = 16'h0010;
    step();
    y_ack = '0;
    check("empty_occ", 256'(occupancy), 256'd0);

    // Fill all channels
    for (int k = 0; k < 16; k++) begin
      write(4'(k), 16'h0100 + 16'(k));
      check($sformatf("fill_occ%0d", k), 256'(occupancy), 256'(k + 1));
    end
    check("full_valid", 256'(y_valid), 256'hFFFF);
    in_valid = 1'b1;
    for (int k = 0; k < 16; k += 5) begin
      in_sel = 4'(k);
      #1;
      check($sformatf("full_ready%0d", k), 256'(in_ready), 256'd0);
    end
    in_valid = 1'b0;

    // Ack everything in one cycle; data is retained
    exp_out = '0;
    for (int k = 0; k < 16; k++) exp_out[k*16 +: 16] = 16'h0100 + 16'(k);
    y_ack = 16'hFFFF;
    step();
    y_ack = '0;
    check("ackall_valid", 256'(y_valid), 256'h0);
    check("ackall_occ", 256'(occupancy), 256'd0);
    check("ackall_data", y_out, exp_out);
    y_ack = 16'h0020;
    step();
    y_ack = '0;
    check("spur_valid", 256'(y_valid), 256'h0);
    check("spur_occ", 256'(occupancy), 256'd0);
    check("spur_data", y_out, exp_out);

    // Synchronous clear beats a pending write
    write(4'd2, 16'hCAFE);
    check("preclr_occ", 256'(occupancy), 256'd1);
    clr = 1'b1; in_valid = 1'b1; in_sel = 4'd7; in_data = 16'hBEEF;
    #1;
    check("clr_ready", 256'(in_ready), 256'd0);
    step();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_out", y_out, 256'h0);
    check("clr_valid", 256'(y_valid), 256'h0);
    check("clr_occ", 256'(occupancy), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
